oam_dma: RTL and testbench

- Sprite DMA engine on the CPU side of the PPU, directly upstream of the PPU register port.
- A CPU write to $4014 triggers it. It halts the CPU, reads 256 bytes from page {page,8'h00} of CPU memory, and writes each byte to OAMDATA through the PPU's cpu_cs/cpu_rw/cpu_addr/cpu_data_i interface.
- It runs on the PPU clock and advances only on CPU-cycle enables.

---
 rtl/ppu_pkg.sv | 24 ++
 rtl/oam_dma.sv | 82 ++++++++
 tb/tb_oam_dma.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: CPU-visible register indices, the $4014 DMA
// register address and the sprite DMA state encoding.
package ppu_pkg;

    localparam logic [2:0] PPUCTRL   = 3'h0;
    localparam logic [2:0] PPUMASK   = 3'h1;
    localparam logic [2:0] PPUSTATUS = 3'h2;
    localparam logic [2:0] OAMADDR   = 3'h3;
    localparam logic [2:0] OAMDATA   = 3'h4;
    localparam logic [2:0] PPUSCROLL = 3'h5;
    localparam logic [2:0] PPUADDR   = 3'h6;
    localparam logic [2:0] PPUDATA   = 3'h7;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: copies one CPU page into OAMDATA, one read+write per byte pair of CPU cycles.
// Latency: 513 CPU cycles from trigger to done (514 on odd start); stalls whenever ce is low.
module oam_dma
    import ppu_pkg::*;
#(
    parameter int         NBYTES       = 256,
    parameter logic [2:0] OAMDATA_ADDR = OAMDATA,
    parameter bit         ODD_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        trig,
    input  logic [7:0]  page,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data_i,
    output logic        ppu_cs,
    output logic        ppu_rw,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_data,
    output logic        halt,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST = 8'(NBYTES - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q;
    logic [7:0] cnt_q;
    logic [7:0] ppu_data_q;
    logic       parity_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            page_q     <= 8'h00;
            cnt_q      <= 8'h00;
            ppu_data_q <= 8'h00;
            parity_q   <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            if (state_q == IDLE && trig) begin
                page_q <= page;
                cnt_q  <= 8'h00;
            end
            if (state_q == READ) begin
                ppu_data_q <= mem_data_i;
            end
            if (state_q == WRITE && cnt_q != LAST) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // parity_q has already toggled past the trigger cycle, so 0 here means the start was odd
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig) state_d = HALT;
            HALT:    state_d = (ODD_ALIGN && !parity_q) ? ALIGN : READ;
            ALIGN:   state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = (cnt_q == LAST) ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd   = (state_q == READ);
    assign mem_addr = mem_rd ? {page_q, cnt_q} : 16'h0000;
    assign ppu_rw   = (state_q != WRITE);
    assign ppu_addr = (state_q == WRITE) ? OAMDATA_ADDR : 3'h0;
    assign ppu_data = ppu_data_q;
    // rst gating keeps a reset that lands mid-WRITE from leaking a partial strobe
    assign ppu_cs   = rst && ce && (state_q == WRITE);
    assign done     = ppu_cs && (cnt_q == LAST);
    assign halt     = (state_q != IDLE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a byte-array CPU memory as source, a write recorder as OAM sink.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        trig = 1'b0;
    logic [7:0]  page = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_i;
    logic        ppu_cs;
    logic        ppu_rw;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_data;
    logic        halt;
    logic        busy;
    logic        done;

    logic [7:0] mem [0:65535];
    assign mem_data_i = mem[mem_addr];

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .trig       (trig),
        .page       (page),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data_i (mem_data_i),
        .ppu_cs     (ppu_cs),
        .ppu_rw     (ppu_rw),
        .ppu_addr   (ppu_addr),
        .ppu_data   (ppu_data),
        .halt       (halt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          ce_n, accept_ce, done_ce, done_cnt, halt_ces, first_rd, rd_cnt;
    int          busy_falls, cs_bad, held_bad, stall_hits;
    logic [15:0] rd_min, rd_max;
    int          zero_hit;
    logic        prev_busy;
    logic [7:0]  wr_q [$];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        done_ce = -1; done_cnt = 0; halt_ces = 0; first_rd = -1; rd_cnt = 0;
        busy_falls = 0; cs_bad = 0; held_bad = 0; stall_hits = 0;
        rd_min = 16'hFFFF; rd_max = 16'h0000; zero_hit = 0;
        wr_q.delete();
    endtask

    // drive on the falling edge, observe 1ns later, well clear of the rising edge
    task automatic step(input logic c, input logic t, input logic [7:0] p);
        @(negedge clk);
        ce = c; trig = t; page = p;
        #1;
        if (ppu_cs && (!c || ppu_addr !== 3'h4 || ppu_rw !== 1'b0)) cs_bad++;
        if (done && !c) cs_bad++;
        if (c) begin
            ce_n++;
            if (halt) halt_ces++;
            if (mem_rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = ce_n;
                if (mem_addr < rd_min) rd_min = mem_addr;
                if (mem_addr > rd_max) rd_max = mem_addr;
                if (mem_addr == 16'h0000) zero_hit++;
            end
            if (ppu_cs) wr_q.push_back(ppu_data);
            if (done) begin done_cnt++; done_ce = ce_n; end
            if (prev_busy && !busy) busy_falls++;
            prev_busy = busy;
        end
    endtask

    task automatic cyc(input logic t, input logic [7:0] p);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, t, p);
    endtask

    task automatic start(input logic odd, input logic [7:0] p);
        clear_mon();
        if (ce_n[0] != odd) cyc(1'b0, 8'h00);
        cyc(1'b1, p);
        accept_ce = ce_n;
    endtask

    // steps CPU cycles until one ce past done, or until stop_wr writes have been seen
    task automatic run(input int stop_wr, input int trig_wr, input logic [7:0] trig_pg,
                       input int trig_rel, input int stall_rd);
        int          n;
        bit          fired, seen_done;
        logic        t;
        logic [28:0] snap;
        n = 0; fired = 0; seen_done = 0;
        while (n < 2000) begin
            if (stop_wr >= 0 && wr_q.size() == stop_wr) break;
            t = 1'b0;
            if (!fired && trig_wr >= 0 && wr_q.size() == trig_wr) begin t = 1'b1; fired = 1; end
            if (!fired && trig_rel >= 0 && ce_n + 1 == accept_ce + trig_rel) begin t = 1'b1; fired = 1; end
            step(1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00);
            if (stall_hits == 0 && stall_rd >= 0 && rd_cnt == stall_rd && mem_rd) begin
                stall_hits++;
                snap = {mem_addr, mem_rd, halt, busy, ppu_data, ppu_cs, ppu_rw};
                repeat (10) begin
                    step(1'b0, 1'b0, 8'h00);
                    if ({mem_addr, mem_rd, halt, busy, ppu_data, ppu_cs, ppu_rw} !== snap) held_bad++;
                end
            end
            step(1'b1, t, trig_pg);
            if (seen_done) break;
            if (done_cnt > 0) seen_done = 1;
            n++;
        end
    endtask

    function automatic int data_errs(input logic [7:0] pg);
        int errs = 0;
        for (int i = 0; i < wr_q.size(); i++) begin
            if (wr_q[i] !== mem[{pg, 8'(i)}]) errs++;
        end
        return errs;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'h5A;
            mem[{8'h03, 8'(i)}] = 8'(i) ^ 8'h11;
            mem[{8'hFF, 8'(i)}] = 8'(i) ^ 8'hC3;
        end
        mem[16'h0000] = 8'hEE;
        ce_n = 0; prev_busy = 1'b0;
        clear_mon();

        // reset state
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_rd",   mem_rd,   0);
        check("rst_ppu_cs",   ppu_cs,   0);
        check("rst_ppu_rw",   ppu_rw,   1);
        check("rst_ppu_addr", ppu_addr, 0);
        check("rst_ppu_data", ppu_data, 0);
        check("rst_halt",     halt,     0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        rst = 1'b1;
        ce_n = 0; prev_busy = 1'b0;

        // trig without ce is ignored
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b0, 8'h00);
        check("noce_trig_busy", busy, 0);

        // even start, with a second trig landing on the done ce
        start(1'b0, 8'h02);
        run(-1, -1, 8'h00, 513, -1);
        check("even_nwr",      wr_q.size(), 256);
        check("even_data",     data_errs(8'h02), 0);
        check("even_first",    wr_q[0], 8'h5A);
        check("even_second",   wr_q[1], 8'h5B);
        check("even_last",     wr_q[255], 8'hA5);
        check("even_cs_bad",   cs_bad, 0);
        check("even_done_ce",  done_ce - accept_ce, 513);
        check("even_halt_ces", halt_ces, 513);
        check("even_first_rd", first_rd - accept_ce, 2);
        check("even_done_cnt", done_cnt, 1);
        check("done_trig_busy", busy, 0);
        check("even_busy_fall", busy_falls, 1);

        // odd start
        start(1'b1, 8'h02);
        run(-1, -1, 8'h00, -1, -1);
        check("odd_nwr",      wr_q.size(), 256);
        check("odd_data",     data_errs(8'h02), 0);
        check("odd_done_ce",  done_ce - accept_ce, 514);
        check("odd_halt_ces", halt_ces, 514);
        check("odd_first_rd", first_rd - accept_ce, 3);

        // page FF ends at FFFF without carrying into 0000
        start(1'b0, 8'hFF);
        run(-1, -1, 8'h00, -1, -1);
        check("ff_rd_min",   rd_min, 16'hFF00);
        check("ff_rd_max",   rd_max, 16'hFFFF);
        check("ff_rd_cnt",   rd_cnt, 256);
        check("ff_zero_hit", zero_hit, 0);
        check("ff_data",     data_errs(8'hFF), 0);
        check("ff_last",     wr_q[255], 8'h3C);

        // trig while busy is ignored
        start(1'b0, 8'h02);
        run(-1, 100, 8'h03, -1, -1);
        check("ign_nwr",       wr_q.size(), 256);
        check("ign_data",      data_errs(8'h02), 0);
        check("ign_busy_fall", busy_falls, 1);
        check("ign_done_cnt",  done_cnt, 1);

        // reset mid-transfer, then a clean retrigger
        start(1'b0, 8'h02);
        run(40, -1, 8'h00, -1, -1);
        @(negedge clk);
        ce = 1'b0; rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        check("abort_ppu_cs",   ppu_cs, 0);
        check("abort_halt",     halt, 0);
        check("abort_busy",     busy, 0);
        check("abort_mem_rd",   mem_rd, 0);
        check("abort_done_cnt", done_cnt, 0);
        rst = 1'b1;
        ce_n = 0; prev_busy = 1'b0;
        start(1'b0, 8'h02);
        run(-1, -1, 8'h00, -1, -1);
        check("retrig_nwr",      wr_q.size(), 256);
        check("retrig_first",    wr_q[0], 8'h5A);
        check("retrig_data",     data_errs(8'h02), 0);
        check("retrig_done_cnt", done_cnt, 1);
        check("retrig_done_ce",  done_ce - accept_ce, 513);

        // 10-clk ce stall in the middle of a READ
        start(1'b0, 8'h02);
        run(-1, -1, 8'h00, -1, 77);
        check("stall_hit",     stall_hits, 1);
        check("stall_held",    held_bad, 0);
        check("stall_data",    data_errs(8'h02), 0);
        check("stall_nwr",     wr_q.size(), 256);
        check("stall_done_ce", done_ce - accept_ce, 513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
